// File: rtl/rfrac_mr2bin_conv_pkg.sv
// Shared types and default constants for the fractional mixed-radix to binary converter.
package rfrac_conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_e;

    // MODULI[k] is the radix applied before adding digit k; index 0 is the rightmost field.
    localparam logic [4*18-1:0] DEF_MODULI =
        {18'd262049, 18'd262027, 18'd177147, 18'd117649};

    localparam logic [4*16-1:0] DEF_SIGN_CONST =
        {16'd27746, 16'd28157, 16'd36804, 16'd14087};

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rfrac_mr2bin_conv_if.sv
// Request/result bundle of the converter; master drives requests, slave is the converter.
interface rfrac_mr2bin_conv_if #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_WIDTH = 18,
    parameter int WORD_WIDTH  = 16,
    parameter int NUM_WORDS   = 4
);
    // Handshake: a transfer happens on a clock edge where valid and ready are both high.
    // Once raised, out_valid and all result fields hold stable until that transfer;
    // in_ready depends only on converter state, never combinationally on in_valid.
    logic                              in_valid;
    logic                              in_ready;
    logic [NUM_DIGITS*DIGIT_WIDTH-1:0] digits_in;
    logic                              sign_in;
    logic                              rnd_in;
    logic                              out_valid;
    logic                              out_ready;
    logic [NUM_WORDS*WORD_WIDTH-1:0]   words_out;
    logic                              sign_out;
    logic [DIGIT_WIDTH-1:0]            ov_mul_out;
    logic                              ov_corr_out;
    logic                              ovf_out;

    modport master (
        output in_valid, digits_in, sign_in, rnd_in, out_ready,
        input  in_ready, out_valid, words_out, sign_out, ov_mul_out, ov_corr_out, ovf_out
    );

    modport slave (
        input  in_valid, digits_in, sign_in, rnd_in, out_ready,
        output in_ready, out_valid, words_out, sign_out, ov_mul_out, ov_corr_out, ovf_out
    );

endinterface

// File: rtl/rfrac_mr2bin_conv_mac.sv
// Combinational word multiply-add {hi,lo} = a*m + c, shared by the digit and correction passes.
module mr_word_mac #(
    parameter int WORD_WIDTH  = 16,
    parameter int DIGIT_WIDTH = 18
) (
    input  logic [WORD_WIDTH-1:0]  a,
    input  logic [DIGIT_WIDTH-1:0] m,
    input  logic [DIGIT_WIDTH-1:0] c,
    output logic [DIGIT_WIDTH-1:0] hi,
    output logic [WORD_WIDTH-1:0]  lo
);
    localparam int PW = WORD_WIDTH + DIGIT_WIDTH;

    logic [PW-1:0] sum;

    // Max is (2^WW-1)(2^DW-1) + 2^DW-1 < 2^(WW+DW), so no bit is lost.
    assign sum      = PW'(a) * PW'(m) + PW'(c);
    assign {hi, lo} = sum;

endmodule

// File: rtl/rfrac_mr2bin_conv.sv
// Word-serial Horner evaluation of mixed-radix digits followed by a sign-gated constant correction.
module rfrac_mr2bin_conv
    import rfrac_conv_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_WIDTH = 18,
    parameter int WORD_WIDTH  = 16,
    parameter int NUM_WORDS   = 4,
    parameter logic [NUM_DIGITS*DIGIT_WIDTH-1:0] MODULI     = DEF_MODULI,
    parameter logic [NUM_WORDS*WORD_WIDTH-1:0]   SIGN_CONST = DEF_SIGN_CONST
) (
    input  logic                    clk,
    input  logic                    reset,
    rfrac_mr2bin_conv_if.slave      bus,
    output state_e                  state_dbg
);
    localparam int DI_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam int WI_W = (NUM_WORDS > 1) ? clog2(NUM_WORDS) : 1;
    localparam logic [DI_W-1:0] D_LAST = DI_W'(NUM_DIGITS - 1);
    localparam logic [WI_W-1:0] J_LAST = WI_W'(NUM_WORDS - 1);

    if (NUM_DIGITS < 1 || NUM_WORDS < 1) begin : g_bad_size
        $error("rfrac_mr2bin_conv: NUM_DIGITS and NUM_WORDS must be at least 1");
    end
    // The correction carry-in reaches SIGN_CONST word + 1, which must fit the carry path.
    if (DIGIT_WIDTH <= WORD_WIDTH) begin : g_bad_width
        $error("rfrac_mr2bin_conv: DIGIT_WIDTH must exceed WORD_WIDTH");
    end

    state_e                            state;
    logic [DI_W-1:0]                   d;
    logic [WI_W-1:0]                   j;
    logic [DIGIT_WIDTH-1:0]            carry;
    logic [WORD_WIDTH-1:0]             acc [NUM_WORDS];
    logic [NUM_DIGITS*DIGIT_WIDTH-1:0] digits_r;
    logic                              sign_r;
    logic                              rnd_r;
    logic                              in_ready_r;
    logic                              out_valid_r;
    logic [DIGIT_WIDTH-1:0]            ov_mul_r;
    logic                              ov_corr_r;
    logic                              ovf_r;

    logic [DIGIT_WIDTH-1:0] mod_arr [NUM_DIGITS];
    logic [DIGIT_WIDTH-1:0] dig_arr [NUM_DIGITS];
    logic [WORD_WIDTH-1:0]  sc_arr  [NUM_WORDS];

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digits
        assign mod_arr[k] = MODULI[k*DIGIT_WIDTH +: DIGIT_WIDTH];
        assign dig_arr[k] = digits_r[k*DIGIT_WIDTH +: DIGIT_WIDTH];
    end

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_words
        assign sc_arr[i] = SIGN_CONST[i*WORD_WIDTH +: WORD_WIDTH];
        assign bus.words_out[i*WORD_WIDTH +: WORD_WIDTH] = acc[i];
    end

    logic [WORD_WIDTH-1:0]  mac_a;
    logic [DIGIT_WIDTH-1:0] mac_m;
    logic [DIGIT_WIDTH-1:0] mac_c;
    logic [DIGIT_WIDTH-1:0] mac_hi;
    logic [WORD_WIDTH-1:0]  mac_lo;
    logic                   k_in;

    // CORR reuses the multiplier with m=1; word 0 takes the rounding bit as carry-in.
    always_comb begin
        mac_a = acc[j];
        k_in  = (j == '0) ? rnd_r : carry[0];
        if (state == CORR) begin
            mac_m = DIGIT_WIDTH'(1);
            mac_c = (sign_r ? DIGIT_WIDTH'(sc_arr[j]) : '0) + DIGIT_WIDTH'(k_in);
        end else begin
            mac_m = mod_arr[d];
            mac_c = (j == '0) ? dig_arr[d] : carry;
        end
    end

    mr_word_mac #(
        .WORD_WIDTH (WORD_WIDTH),
        .DIGIT_WIDTH(DIGIT_WIDTH)
    ) u_mac (
        .a (mac_a),
        .m (mac_m),
        .c (mac_c),
        .hi(mac_hi),
        .lo(mac_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            d           <= '0;
            j           <= '0;
            carry       <= '0;
            for (int i = 0; i < NUM_WORDS; i++) acc[i] <= '0;
            digits_r    <= '0;
            sign_r      <= 1'b0;
            rnd_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            ov_mul_r    <= '0;
            ov_corr_r   <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        digits_r   <= bus.digits_in;
                        sign_r     <= bus.sign_in;
                        rnd_r      <= bus.rnd_in;
                        for (int i = 0; i < NUM_WORDS; i++) acc[i] <= '0;
                        carry      <= '0;
                        d          <= D_LAST;
                        j          <= '0;
                        ov_mul_r   <= '0;
                        ov_corr_r  <= 1'b0;
                        ovf_r      <= 1'b0;
                        in_ready_r <= 1'b0;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    acc[j] <= mac_lo;
                    carry  <= mac_hi;
                    if (j == J_LAST) begin
                        j <= '0;
                        if (mac_hi != '0) ovf_r <= 1'b1;
                        if (d == '0) begin
                            ov_mul_r <= mac_hi;
                            state    <= CORR;
                        end else begin
                            d <= d - 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                CORR: begin
                    acc[j] <= mac_lo;
                    carry  <= mac_hi;
                    if (j == J_LAST) begin
                        ov_corr_r   <= mac_hi[0];
                        ovf_r       <= ovf_r | mac_hi[0];
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.sign_out    = sign_r;
    assign bus.ov_mul_out  = ov_mul_r;
    assign bus.ov_corr_out = ov_corr_r;
    assign bus.ovf_out     = ovf_r;
    assign state_dbg       = state;

endmodule

// File: doc/rfrac_mr2bin_conv.md
Name: rfrac_mr2bin_conv

Overview:
- Parametrised, word-serial successor to the fixed 4-digit fractional mixed-radix-to-binary converter stage.
- Evaluates a mixed-radix value by Horner's rule into NUM_WORDS binary words of WORD_WIDTH bits, using one shared multiply-add unit.
- Then applies a sign-gated constant correction with a rounding carry-in.
- Sits after the RNS-to-mixed-radix stage in the TPU output path; adds a valid/ready handshake, reset and an overflow summary, none of which the fixed-depth pipeline has.

Parameters:
- NUM_DIGITS, 4, number of mixed-radix digits; digit 0 is least significant.
- DIGIT_WIDTH, 18, width of each digit, each modulus and the carry.
- WORD_WIDTH, 16, width of each binary output word.
- NUM_WORDS, 4, number of binary output words; word 0 is least significant.
- MODULI, {262049,262027,177147,117649} (index 3 down to 0), packed NUM_DIGITS*DIGIT_WIDTH; MODULI[k] is the radix applied before adding digit k.
- SIGN_CONST, {27746,28157,36804,14087} (word 3 down to 0), packed NUM_WORDS*WORD_WIDTH; correction constant added when sign is set.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input conversion request.
- in_ready  out  1  high only in IDLE.
- digits_in  in  NUM_DIGITS*DIGIT_WIDTH  mixed-radix digits; digit k is at [k*DIGIT_WIDTH +: DIGIT_WIDTH].
- sign_in  in  1  enables the SIGN_CONST correction.
- rnd_in  in  1  rounding carry-in to the correction.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- words_out  out  NUM_WORDS*WORD_WIDTH  binary result.
- sign_out  out  1  sign_in of this conversion.
- ov_mul_out  out  DIGIT_WIDTH  top-word carry of the final digit step.
- ov_corr_out  out  1  carry out of the correction add.
- ovf_out  out  1  any overflow occurred in this conversion.

Behaviour:
- Reset: all outputs 0, except in_ready=1; FSM goes to IDLE; accumulator, counters and flags are cleared. Reset in any state aborts the conversion and no result is produced.
- Accept: on in_valid&in_ready, latch digits, sign and rnd; clear the accumulator; set digit index d=NUM_DIGITS-1 and word index j=0; go to MAC.
- MAC, one cycle per word:
  - {c_next, acc[j]} = acc[j]*MODULI[d] + c.
  - c is loaded with digit[d] at j=0.
  - The carry fits DIGIT_WIDTH bits, because the sum is at most (2^WW-1)(2^DW-1)+2^DW-1.
  - At j=NUM_WORDS-1: if c_next≠0, set ovf; if d==0, latch c_next into ov_mul; otherwise d--, j=0.
  - When d==0 and j==NUM_WORDS-1, go to CORR.
- CORR, one cycle per word:
  - {k, acc[j]} = acc[j] + (sign ? SIGN_CONST[j] : 0) + k.
  - k starts at rnd. The rnd carry-in is added regardless of sign.
  - After the last word, ov_corr=k and ovf|=k; go to DONE.
- DONE: out_valid=1. Outputs hold stable until out_ready. On out_valid&out_ready, go to IDLE next cycle with out_valid=0 and in_ready=1.
- Latency: accept to out_valid is NUM_DIGITS*NUM_WORDS + NUM_WORDS + 1 cycles (21 at defaults). Throughput is one conversion per latency+1 cycles.
- No overlap: in_valid is ignored outside IDLE. Holding out_ready high gives back-to-back results.
- Width rules and elaboration checks:
  - All arithmetic is unsigned.
  - Every MODULI entry must be < 2^DIGIT_WIDTH.
  - NUM_DIGITS ≥ 1 and NUM_WORDS ≥ 1, enforced by an elaboration-time check.
  - The index counters use clog2 widths.

Decomposition:
- Package rfrac_conv_pkg holds:
  - the state enum (IDLE, MAC, CORR, DONE);
  - the default MODULI and SIGN_CONST constants;
  - a clog2 helper.
- One sub-module, mr_word_mac: combinational {hi,lo} = a*m + c with a=WORD_WIDTH bits and m,c,hi=DIGIT_WIDTH bits. It is shared by MAC and reused for CORR with m=1.
- The FSM, counters and accumulator register file live in the top module.

Test Plan:
- All digits 0, sign=0, rnd=0 -> words_out=0, ov_mul=0, ov_corr=0, ovf=0, out_valid exactly 21 cycles after accept.
- digit0=5, others 0, sign=0, rnd=1 -> word0=6, other words 0, ovf=0.
- digit1=1, others 0, sign=0, rnd=0 -> 117649: word0=0xCB91, word1=0x0001, words 2 and 3 =0.
- All digits 0, sign=1, rnd=1 -> words={27746,28157,36804,14088}, ov_corr=0.
- All digits 0x3FFFF, sign=1 -> ovf=1 with nonzero ov_mul; result is compared against the reference model truncated modulo 2^64.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles -> out_valid and words stable, in_valid ignored.
  - Assert reset in mid-MAC -> next cycle out_valid=0, in_ready=1, and a following conversion is correct.
